// File: rtl/recovery_sequencer.sv
// recovery_sequencer: drain, flush, RAT restore and fetch redirect after a mispredict or exception (optional RECOVERY_BULK_COPY_EN)
module recovery_sequencer #(
   parameter int          RETRAT_WIDTH = 6,
   parameter int          RETRAT_DEPTH = 32,
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] EXCP_VECTOR  = 32'h0000_0080
) (
   input  logic                                 CLK,
   input  logic                                 RESET,
   input  logic                                 FREEZE,
   input  logic                                 misp_req_IN,
   input  logic [31:0]                          misp_target_PC_IN,
   input  logic                                 excp_req_IN,
   input  logic                                 memPending_IN,
   input  logic [RETRAT_WIDTH*RETRAT_DEPTH-1:0] retRat_IN,
   output logic                                 busy_OUT,
   output logic                                 flushEm_OUT,
   output logic                                 ratWrEn_OUT,
   output logic [$clog2(RETRAT_DEPTH)-1:0]      ratWrIdx_OUT,
   output logic [RETRAT_WIDTH-1:0]              ratWrData_OUT,
   output logic                                 copyRetRat_OUT,
   output logic                                 fROB_set_PC_OUT,
   output logic [31:0]                          fROB_target_PC_OUT
);
   localparam int IW = $clog2(RETRAT_DEPTH);
   typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, RESTORE, REDIRECT} state_t;
   state_t                  state, state_n;
   logic [3:0]              cnt, cnt_n;
   logic [IW-1:0]           idx, idx_n;
   logic [31:0]             tgt, tgt_n;
   logic                    busy_n, flush_n, wren_n, copy_n, setpc_n;
   logic [IW-1:0]           widx_n;
   logic [RETRAT_WIDTH-1:0] wdata_n;
   logic [31:0]             tpc_n;
   logic [RETRAT_WIDTH-1:0] ent [RETRAT_DEPTH];
   for (genvar i = 0; i < RETRAT_DEPTH; i++) begin : g_ent
      assign ent[i] = retRat_IN[(RETRAT_DEPTH-1-i)*RETRAT_WIDTH +: RETRAT_WIDTH];
   end
   // state, counters, latched target and registered outputs; FREEZE holds everything
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state              <= IDLE;
         cnt                <= '0;
         idx                <= '0;
         tgt                <= '0;
         busy_OUT           <= 1'b0;
         flushEm_OUT        <= 1'b0;
         ratWrEn_OUT        <= 1'b0;
         ratWrIdx_OUT       <= '0;
         ratWrData_OUT      <= '0;
         copyRetRat_OUT     <= 1'b0;
         fROB_set_PC_OUT    <= 1'b0;
         fROB_target_PC_OUT <= '0;
      end else if (!FREEZE) begin
         state              <= state_n;
         cnt                <= cnt_n;
         idx                <= idx_n;
         tgt                <= tgt_n;
         busy_OUT           <= busy_n;
         flushEm_OUT        <= flush_n;
         ratWrEn_OUT        <= wren_n;
         ratWrIdx_OUT       <= widx_n;
         ratWrData_OUT      <= wdata_n;
         copyRetRat_OUT     <= copy_n;
         fROB_set_PC_OUT    <= setpc_n;
         fROB_target_PC_OUT <= tpc_n;
      end
   end
   // next state and counters; exception beats a simultaneous mispredict
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      tgt_n   = tgt;
      case (state)
         IDLE: if (excp_req_IN || misp_req_IN) begin
            state_n = DRAIN;
            tgt_n   = excp_req_IN ? EXCP_VECTOR : misp_target_PC_IN;
         end
         DRAIN: if (!memPending_IN) begin
            state_n = FLUSH;
            cnt_n   = 4'(FLUSH_CYCLES - 1);
         end
         FLUSH: if (cnt == 4'd0) state_n = RESTORE;
                else cnt_n = cnt - 4'd1;
`ifdef RECOVERY_BULK_COPY_EN
         RESTORE: state_n = REDIRECT;
`else
         RESTORE: if (idx == IW'(RETRAT_DEPTH - 1)) begin
            state_n = REDIRECT;
            idx_n   = '0;
         end else idx_n = idx + IW'(1);
`endif
         REDIRECT: state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end
   // outputs for the cycle entered on the next edge, so every output comes straight from a flop
   always_comb begin
      busy_n  = state_n != IDLE;
      flush_n = state_n == FLUSH;
      setpc_n = state_n == REDIRECT;
      tpc_n   = setpc_n ? tgt_n : fROB_target_PC_OUT;
`ifdef RECOVERY_BULK_COPY_EN
      wren_n  = 1'b0;
      copy_n  = state_n == RESTORE;
      widx_n  = '0;
      wdata_n = '0;
`else
      wren_n  = state_n == RESTORE;
      copy_n  = 1'b0;
      widx_n  = wren_n ? idx_n : '0;
      wdata_n = wren_n ? ent[idx_n] : '0;
`endif
   end
endmodule

// File: doc/recovery_sequencer.md
Name: recovery_sequencer

Overview:
Sequences pipeline recovery after commit detects a mispredicted jump/branch or an excepting ROB head. It accepts one recovery request, waits for outstanding memory operations to drain, and holds the flush for a fixed number of cycles. It then restores the front-end RAT from the retirement RAT and redirects fetch. Sits between the commit stage, the rename RAT, fetch PC logic and all flushable queues, and replaces their ad-hoc flush/copy wiring.

Parameters:
RETRAT_WIDTH, 6, physical register ID width
RETRAT_DEPTH, 32, architectural registers; RAT entries to restore
FLUSH_CYCLES, 2, cycles flushEm_OUT is held (1..15)
EXCP_VECTOR, 32'h0000_0080, fetch target on exception

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
FREEZE  in  1  global stall; all state and counters hold
misp_req_IN  in  1  mispredict recovery request (one-cycle pulse)
misp_target_PC_IN  in  32  correct fetch target for misp_req_IN
excp_req_IN  in  1  exception recovery request (one-cycle pulse)
memPending_IN  in  1  outstanding memory ops not yet complete
retRat_IN  in  RETRAT_WIDTH*RETRAT_DEPTH  packed retirement RAT; entry 0 in MSBs, entry DEPTH-1 in LSBs
busy_OUT  out  1  recovery in progress; commit and rename must stall
flushEm_OUT  out  1  flush all queues, ROB and reservation stations
ratWrEn_OUT  out  1  front-end RAT write enable
ratWrIdx_OUT  out  log2(RETRAT_DEPTH)  RAT entry written
ratWrData_OUT  out  RETRAT_WIDTH  physical register ID written
copyRetRat_OUT  out  1  bulk-copy strobe (RECOVERY_BULK_COPY_EN only; tied 0 otherwise)
fROB_set_PC_OUT  out  1  fetch redirect strobe
fROB_target_PC_OUT  out  32  redirect target

Behaviour:
- All outputs are registered. Each output is asserted during the cycles the FSM is in the state that drives it.
- Reset: state=IDLE, counters=0, latched target=0, all outputs 0. RESET mid-recovery aborts to IDLE on the next edge, with no redirect issued.
- FREEZE high (RESET low): state, counters, latched target and outputs hold their values. Requests arriving during FREEZE are ignored, not queued.
- IDLE: on edge with misp_req_IN or excp_req_IN high -> DRAIN. Latch target: EXCP_VECTOR if excp_req_IN, else misp_target_PC_IN.
- Simultaneous misp_req_IN and excp_req_IN: exception wins.
- Requests while busy_OUT=1 are ignored. Commit is stalled, so this case is a protocol error only.
- DRAIN: busy_OUT=1. Stays while memPending_IN=1; goes to FLUSH on the first edge where it is 0.
- FLUSH: busy_OUT=1, flushEm_OUT=1 for exactly FLUSH_CYCLES cycles (counter counts down), then -> RESTORE.
- RESTORE (sequential mode): one entry per cycle, idx 0 to DEPTH-1.
  - ratWrEn_OUT=1, ratWrIdx_OUT=idx.
  - ratWrData_OUT = entry idx of retRat_IN, sampled in that cycle.
  - After idx=DEPTH-1 -> REDIRECT. The index counter wraps to 0.
- REDIRECT: fROB_set_PC_OUT=1 and fROB_target_PC_OUT=latched target for one cycle, busy_OUT=1, then -> IDLE.
- fROB_target_PC_OUT holds its last value in other states. The strobe is the only qualifier.
- Latency, with memPending_IN=0, FLUSH_CYCLES=2, DEPTH=32, request sampled at edge 0:
  - DRAIN in cycle 1
  - FLUSH in cycles 2-3
  - RESTORE in cycles 4-35
  - REDIRECT in cycle 36
  - IDLE and busy_OUT=0 from cycle 37
- retRat_IN must be stable from DRAIN through RESTORE. Commit is stalled, so it is.

Optional Feature:
RECOVERY_BULK_COPY_EN
- Defined: RESTORE lasts one cycle with copyRetRat_OUT=1 and ratWrEn_OUT=0; the front-end RAT bulk-loads retRat_IN. With the latency example above, REDIRECT falls in cycle 5.
- Undefined: the sequential per-entry restore above is used, and copyRetRat_OUT is constant 0.

Test Plan:
- Mispredict: misp_req_IN pulse with target 0x0000_1040, memPending_IN=0 -> flushEm_OUT high for cycles 2-3. Then 32 RAT writes, idx 0..31, data matching retRat_IN. Then fROB_set_PC_OUT pulses once with 0x0000_1040 in cycle 36; busy_OUT=0 in cycle 37.
- Simultaneous excp_req_IN and misp_req_IN (target 0x2000) -> redirect to 0x0000_0080.
- memPending_IN held high for 10 cycles after the request -> DRAIN lasts 10 cycles, with no flush or RAT write before memPending_IN falls. Total latency grows by 9 cycles.
- FREEZE held 5 cycles at RESTORE idx=7 -> ratWrIdx_OUT stays 7, then resumes at 8. No entries are skipped or duplicated, and the redirect is delayed by exactly 5 cycles.
- RESET asserted at RESTORE idx=12 -> next cycle all outputs 0 and state IDLE. A new request afterwards restarts at DRAIN and restores from idx 0.
- New misp_req_IN during FLUSH -> ignored; exactly one redirect, with the first target.
